// File: rtl/led_drv_pkg.sv
// Shared types and constants for the multi-channel LED status driver.
package led_drv_pkg;

  localparam int unsigned MODE_W   = 3;
  localparam int unsigned PERIOD_W = 16;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 3'd0,
    MODE_ON      = 3'd1,
    MODE_BLINK   = 3'd2,
    MODE_PWM     = 3'd3,
    MODE_BREATHE = 3'd4
  } led_mode_t;

  // Channel 0 powers up as the 1 Hz / 50% heartbeat; the rest stay dark.
  localparam logic [MODE_W-1:0]   CH0_RST_MODE   = MODE_BLINK;
  localparam logic [PERIOD_W-1:0] CH0_RST_PERIOD = 16'd1000;
  localparam logic [MODE_W-1:0]   CHN_RST_MODE   = MODE_OFF;
  localparam logic [PERIOD_W-1:0] CHN_RST_PERIOD = 16'd0;

  localparam logic [PERIOD_W-1:0] BLINK_MIN_PERIOD   = 16'd2;
  localparam logic [PERIOD_W-1:0] BREATHE_MIN_PERIOD = 16'd1;

  function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p,
                                                       input logic [PERIOD_W-1:0] lo);
    return (p < lo) ? lo : p;
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel engine: config registers, tick-driven phase/level and the output flop.
module led_channel
  import led_drv_pkg::*;
#(
  parameter int unsigned          PWM_BITS   = 8,
  parameter logic [MODE_W-1:0]    RST_MODE   = CHN_RST_MODE,
  parameter logic [PERIOD_W-1:0]  RST_PERIOD = CHN_RST_PERIOD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                load,
  input  logic [MODE_W-1:0]   cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] LVL_TOP = '1;

  logic [MODE_W-1:0]   mode, mode_next;
  logic [PERIOD_W-1:0] period, period_next;
  logic [PWM_BITS-1:0] duty, duty_next;
  logic [PERIOD_W-1:0] phase, phase_next;
  logic [PWM_BITS-1:0] level, level_next;
  logic                dir_up, dir_up_next;
  logic                led_next;
  logic [PERIOD_W-1:0] p_blink, p_breathe;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode   <= RST_MODE;
      period <= RST_PERIOD;
      duty   <= '0;
      phase  <= '0;
      level  <= '0;
      dir_up <= 1'b1;
      led    <= 1'b0;
    end else begin
      mode   <= mode_next;
      period <= period_next;
      duty   <= duty_next;
      phase  <= phase_next;
      level  <= level_next;
      dir_up <= dir_up_next;
      led    <= led_next;
    end
  end

  // Mode engine; a config load overrides any same-edge tick advance.
  always_comb begin
    mode_next   = mode;
    period_next = period;
    duty_next   = duty;
    phase_next  = phase;
    level_next  = level;
    dir_up_next = dir_up;
    led_next    = 1'b0;
    p_blink     = clamp_period(period, BLINK_MIN_PERIOD);
    p_breathe   = clamp_period(period, BREATHE_MIN_PERIOD);

    case (mode)
      MODE_ON: led_next = 1'b1;
      MODE_BLINK: begin
        led_next = (phase < (p_blink >> 1));
        if (tick) phase_next = (phase == p_blink - 16'd1) ? '0 : phase + 16'd1;
      end
      MODE_PWM: led_next = (pwm_cnt < duty);
      MODE_BREATHE: begin
        led_next = (pwm_cnt < level);
        if (tick) begin
          if (phase == p_breathe - 16'd1) begin
            phase_next = '0;
            if (dir_up) begin
              level_next  = level + 1'b1;
              dir_up_next = (level != LVL_TOP - 1'b1);
            end else begin
              level_next  = level - 1'b1;
              dir_up_next = (level == PWM_BITS'(1));
            end
          end else begin
            phase_next = phase + 16'd1;
          end
        end
      end
      default: led_next = 1'b0;
    endcase

    if (load) begin
      mode_next   = cfg_mode;
      period_next = cfg_period;
      duty_next   = cfg_duty;
      phase_next  = '0;
      level_next  = '0;
      dir_up_next = 1'b1;
    end
  end

endmodule

// File: rtl/led_status_driver.sv
// Multi-channel LED status driver: shared ms tick and PWM carrier feeding N_CH channel engines.
module led_status_driver
  import led_drv_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned TICK_HZ     = 1000,
  parameter int unsigned N_CH        = 4,
  parameter int unsigned PWM_BITS    = 8,
  localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk50,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [MODE_W-1:0]   cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic [N_CH-1:0]     led,
  output logic                tick
);

  localparam int unsigned DIV   = CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned CNT_W = $clog2(DIV);

  logic [CNT_W-1:0]    div_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                xfer;

  // tick is high exactly while div_cnt sits at DIV-1, so register it one count early.
  always_ff @(posedge clk50) begin
    if (rst) begin
      div_cnt   <= '0;
      tick      <= 1'b0;
      pwm_cnt   <= '0;
      cfg_ready <= 1'b0;
    end else begin
      div_cnt   <= (div_cnt == CNT_W'(DIV - 1)) ? '0 : div_cnt + 1'b1;
      tick      <= (div_cnt == CNT_W'(DIV - 2));
      pwm_cnt   <= pwm_cnt + 1'b1;
      cfg_ready <= 1'b1;
    end
  end

  assign xfer = cfg_valid & cfg_ready;

  // Out-of-range cfg_ch matches no channel, so such transfers are dropped.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    led_channel #(
      .PWM_BITS  (PWM_BITS),
      .RST_MODE  ((i == 0) ? CH0_RST_MODE : CHN_RST_MODE),
      .RST_PERIOD((i == 0) ? CH0_RST_PERIOD : CHN_RST_PERIOD)
    ) u_ch (
      .clk       (clk50),
      .rst       (rst),
      .tick      (tick),
      .pwm_cnt   (pwm_cnt),
      .load      (xfer && (cfg_ch == CH_W'(i))),
      .cfg_mode  (cfg_mode),
      .cfg_period(cfg_period),
      .cfg_duty  (cfg_duty),
      .led       (led[i])
    );
  end

endmodule

// File: tb/tb_led_status_driver.sv
// Scoreboard bench: closed-form time-based reference model vs. two driver instances.
module tb_led_status_driver;

  localparam int DIV = 10;
  localparam int PWM_TOP = 255;
  localparam int TRI = 2 * PWM_TOP;

  logic clk = 1'b0;
  logic rst, cfg_valid, cfg_ready, tick;
  logic [1:0] cfg_ch;
  logic [2:0] cfg_mode;
  logic [15:0] cfg_period;
  logic [7:0] cfg_duty;
  logic [3:0] led;
  logic cfg_valid3, cfg_ready3, tick3;
  logic [1:0] cfg_ch3;
  logic [2:0] led3;

  always #5 clk = ~clk;

  led_status_driver #(.CLK_FREQ_HZ(10_000), .TICK_HZ(1000), .N_CH(4), .PWM_BITS(8)) dut (
    .clk50(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty), .led(led), .tick(tick));

  // Three-channel instance: channel index 3 is out of range and must be discarded.
  led_status_driver #(.CLK_FREQ_HZ(10_000), .TICK_HZ(1000), .N_CH(3), .PWM_BITS(8)) dut3 (
    .clk50(clk), .rst(rst), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3), .cfg_ch(cfg_ch3),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty), .led(led3), .tick(tick3));

  typedef struct packed {
    logic [3:0] led;
    logic [2:0] led3;
    logic       rdy;
    logic       tck;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_fail = 0;

  // Model state: edges since reset release, and per-channel config plus the edge it was loaded.
  int n = 0;
  bit model_on = 0;
  bit rdy_m = 0;
  int m_mode[4], m_per[4], m_duty[4], m_k[4];
  logic [3:0] pend = '0;
  logic pend3 = 1'b0;

  // Expected LED after edge cyc for a channel configured at edge k.
  function automatic logic chan_led(int m, int per, int duty, int k, int cyc);
    int t, p, s, lvl;
    t = cyc / DIV - k / DIV;
    case (m)
      1: return 1'b1;
      2: begin
        p = (per < 2) ? 2 : per;
        return (t % p) < (p / 2);
      end
      3: return (cyc % 256) < duty;
      4: begin
        p = (per < 1) ? 1 : per;
        s = (t / p) % TRI;
        lvl = (s <= PWM_TOP) ? s : TRI - s;
        return (cyc % 256) < lvl;
      end
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    exp_t e;
    e = '0;
    if (rst) begin
      model_on = 1;
      n = 0;
      rdy_m = 0;
      for (int c = 0; c < 4; c++) begin
        m_mode[c] = (c == 0) ? 2 : 0;
        m_per[c]  = (c == 0) ? 1000 : 0;
        m_duty[c] = 0;
        m_k[c]    = 0;
      end
    end else if (model_on) begin
      e.led  = pend;
      e.led3 = {2'b00, pend3};
      if (cfg_valid && rdy_m) begin
        m_mode[cfg_ch] = int'(cfg_mode);
        m_per[cfg_ch]  = int'(cfg_period);
        m_duty[cfg_ch] = int'(cfg_duty);
        m_k[cfg_ch]    = n + 1;
      end
      n = n + 1;
      rdy_m = 1;
      e.rdy = 1'b1;
      e.tck = (n % DIV == DIV - 1);
    end
    if (model_on) begin
      sb_q.push_back(e);
      for (int c = 0; c < 4; c++) pend[c] = chan_led(m_mode[c], m_per[c], m_duty[c], m_k[c], n);
      pend3 = chan_led(2, 1000, 0, 0, n);
    end
  end

  // Duty-window requests from stimulus; the monitor owns the counting state.
  int win_req = 0;
  int win_ch = 0;
  int win_exp = 0;
  int win_done = 0;
  int win_left = 0;
  int win_cnt = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (led !== e.led) begin
        n_fail++;
        $display("FAIL led @%0t: got %b expected %b", $time, led, e.led);
      end
      n_checks++;
      if ({cfg_ready, tick} !== {e.rdy, e.tck}) begin
        n_fail++;
        $display("FAIL ready/tick @%0t: got %b%b expected %b%b", $time, cfg_ready, tick, e.rdy, e.tck);
      end
      n_checks++;
      if ({led3, cfg_ready3, tick3} !== {e.led3, e.rdy, e.tck}) begin
        n_fail++;
        $display("FAIL dut3 @%0t: got led %b rdy %b tick %b expected led %b rdy %b tick %b",
                 $time, led3, cfg_ready3, tick3, e.led3, e.rdy, e.tck);
      end
    end
    if (win_left > 0) begin
      win_cnt += int'(led[win_ch]);
      win_left--;
      if (win_left == 0) begin
        n_checks++;
        if (win_cnt != win_exp) begin
          n_fail++;
          $display("FAIL pwm window ch%0d: got %0d high cycles expected %0d", win_ch, win_cnt, win_exp);
        end
      end
    end else if (win_req != win_done) begin
      win_done = win_req;
      win_cnt  = int'(led[win_ch]);
      win_left = 255;
    end
  end

  task automatic step();
    @(negedge clk);
    cfg_valid3 = 1'($urandom);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) step();
  endtask

  task automatic xfer(input logic [1:0] ch, input logic [2:0] m, input logic [15:0] p, input logic [7:0] d);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_mode = m; cfg_period = p; cfg_duty = d;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic window(input int ch, input int expv);
    win_ch = ch;
    win_exp = expv;
    win_req++;
    idle(260);
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_period = '0; cfg_duty = '0;
    cfg_valid3 = 1'b0; cfg_ch3 = 2'd3;
    idle(3);
    rst = 1'b0;
    idle(7000);
    // Reset while ch2 runs PWM and ch0 is in its low phase.
    xfer(2'd2, 3'd3, 16'd0, 8'd128);
    idle(5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(5300);
    xfer(2'd1, 3'd1, 16'd0, 8'd0);
    xfer(2'd2, 3'd2, 16'd4, 8'd0);
    idle(200);
    xfer(2'd3, 3'd3, 16'd0, 8'd64);
    idle(10);
    window(3, 64);
    xfer(2'd3, 3'd3, 16'd0, 8'd255);
    idle(10);
    window(3, 255);
    xfer(2'd3, 3'd3, 16'd0, 8'd0);
    idle(10);
    window(3, 0);
    xfer(2'd1, 3'd4, 16'd1, 8'd0);
    idle(5300);
    xfer(2'd2, 3'd2, 16'd0, 8'd0);
    idle(100);
    // Transfer landing on the same edge as a tick.
    for (int i = 0; i < DIV && (n % DIV) != DIV - 1; i++) step();
    xfer(2'd2, 3'd2, 16'd6, 8'd0);
    idle(200);
    // Back-to-back writes to one channel: the second must win.
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_mode = 3'd1; cfg_period = 16'd0; cfg_duty = 8'd0;
    step();
    cfg_mode = 3'd2; cfg_period = 16'd8;
    step();
    cfg_valid = 1'b0;
    idle(200);
    for (int i = 0; i < 3000; i++) begin
      cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_ch     = 2'($urandom);
      cfg_mode   = 3'($urandom);
      cfg_period = 16'($urandom_range(0, 6));
      cfg_duty   = 8'($urandom);
      rst        = (i == 1500);
      step();
    end
    cfg_valid = 1'b0;
    rst = 1'b0;
    idle(300);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
